// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: counts exact matches peg by peg, then colour-only
// matches colour by colour, and records each scored guess in a small history file.
module mastermind_scorer #(
    parameter int PEGS        = 4,
    parameter int NCOLORS     = 6,
    parameter int MAX_GUESSES = 6
) (
    input  logic              ClkPort,
    input  logic              Reset,
    input  logic              start,
    input  logic [3*PEGS-1:0] guess,
    input  logic [3*PEGS-1:0] answer,
    input  logic [2:0]        guess_num,
    input  logic              clear_hist,
    output logic              busy,
    output logic              done,
    output logic [2:0]        black,
    output logic [2:0]        white,
    output logic              win,
    input  logic [2:0]        rd_idx,
    output logic              rd_valid,
    output logic [3*PEGS-1:0] rd_guess,
    output logic [2:0]        rd_black,
    output logic [2:0]        rd_white
);

    localparam int IW = (PEGS > 1) ? $clog2(PEGS) : 1;

    typedef enum logic [1:0] {IDLE, EXACT, COLOR, RESULT} state_t;

    state_t            state;
    logic [3*PEGS-1:0] guess_lat, answer_lat;
    logic [2:0]        num_lat;
    logic [IW-1:0]     peg_idx;
    logic [2:0]        col;
    logic [PEGS-1:0]   matched;
    logic [2:0]        black_cnt, white_cnt;

    logic [2:0]        g_peg [PEGS];
    logic [2:0]        a_peg [PEGS];
    logic [2:0]        gc, ac;

    logic [MAX_GUESSES-1:0] hist_valid;
    logic [3*PEGS-1:0]      hist_guess [MAX_GUESSES];
    logic [2:0]             hist_black [MAX_GUESSES];
    logic [2:0]             hist_white [MAX_GUESSES];

    function automatic logic [2:0] min3(input logic [2:0] x, input logic [2:0] y);
        return (x < y) ? x : y;
    endfunction

    always_comb begin
        for (int p = 0; p < PEGS; p++) begin
            g_peg[p] = guess_lat[3*p +: 3];
            a_peg[p] = answer_lat[3*p +: 3];
        end
    end

    // Occurrences of the current colour among pegs not already counted as black.
    always_comb begin
        gc = '0;
        ac = '0;
        for (int p = 0; p < PEGS; p++) begin
            if (!matched[p] && g_peg[p] == col) gc = gc + 3'd1;
            if (!matched[p] && a_peg[p] == col) ac = ac + 3'd1;
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            black      <= '0;
            white      <= '0;
            win        <= 1'b0;
            guess_lat  <= '0;
            answer_lat <= '0;
            num_lat    <= '0;
            peg_idx    <= '0;
            col        <= '0;
            matched    <= '0;
            black_cnt  <= '0;
            white_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A simultaneous clear_hist takes priority and drops the request.
                    if (start && !clear_hist) begin
                        guess_lat  <= guess;
                        answer_lat <= answer;
                        num_lat    <= guess_num;
                        black_cnt  <= '0;
                        white_cnt  <= '0;
                        matched    <= '0;
                        peg_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= EXACT;
                    end
                end
                EXACT: begin
                    if (g_peg[peg_idx] == a_peg[peg_idx] && g_peg[peg_idx] != 3'd0) begin
                        black_cnt        <= black_cnt + 3'd1;
                        matched[peg_idx] <= 1'b1;
                    end
                    if (peg_idx == IW'(PEGS - 1)) begin
                        col   <= 3'd1;
                        state <= COLOR;
                    end else begin
                        peg_idx <= peg_idx + IW'(1);
                    end
                end
                COLOR: begin
                    white_cnt <= white_cnt + min3(gc, ac);
                    if (col == 3'(NCOLORS)) state <= RESULT;
                    else                    col   <= col + 3'd1;
                end
                RESULT: begin
                    black <= black_cnt;
                    white <= white_cnt;
                    win   <= (black_cnt == 3'(PEGS));
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The in-flight write is placed after the clear so a result landing together
    // with clear_hist still survives.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            hist_valid <= '0;
            for (int s = 0; s < MAX_GUESSES; s++) begin
                hist_guess[s] <= '0;
                hist_black[s] <= '0;
                hist_white[s] <= '0;
            end
        end else begin
            if (clear_hist) hist_valid <= '0;
            if (state == RESULT && int'(num_lat) < MAX_GUESSES) begin
                hist_valid[num_lat] <= 1'b1;
                hist_guess[num_lat] <= guess_lat;
                hist_black[num_lat] <= black_cnt;
                hist_white[num_lat] <= white_cnt;
            end
        end
    end

    always_comb begin
        rd_valid = 1'b0;
        rd_guess = '0;
        rd_black = '0;
        rd_white = '0;
        if (int'(rd_idx) < MAX_GUESSES) begin
            rd_valid = hist_valid[rd_idx];
            rd_guess = hist_guess[rd_idx];
            rd_black = hist_black[rd_idx];
            rd_white = hist_white[rd_idx];
        end
    end

endmodule
